// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types for the pipeline hazard/forwarding controller:
//   state_t    - controller action of the previous cycle (RUN / STALL / FLUSH)
//   fwd_sel_t  - ALU operand select encoding used by the EX-stage operand mux
//   fwd_select - priority encoder for the forwarding source (MEM over WB)
// -----------------------------------------------------------------------------
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,   // operand straight from the register bank
        FWD_MEM = 2'b01,   // alu_resultado_MEM
        FWD_WB  = 2'b10    // write_data_reg
    } fwd_sel_t;

    // The youngest producer (MEM) must win over the older one (WB).
    function automatic fwd_sel_t fwd_select(input logic mem_hit, input logic wb_hit);
        fwd_sel_t sel;
        if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_REG;
        end
        return sel;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// W-bit up counter that sticks at all-ones instead of wrapping.
//   CLK, RESET : clock, synchronous active-high reset (q -> 0)
//   clr        : synchronous clear, wins over inc
//   inc        : count this cycle
//   q          : registered count
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] ALL_ONES = {W{1'b1}};
    localparam logic [W-1:0] ONE      = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    // Next count: clear first, then saturating increment.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = {W{1'b0}};
        end else if (inc && (q_q != ALL_ONES)) begin
            q_d = q_q + ONE;
        end else begin
            q_d = q_q;
        end
    end

    // Count register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            q_q <= {W{1'b0}};
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
// Hazard detection and operand-forwarding controller for the 5-stage pipeline.
// Inputs : CLK, RESET, ID/EX/MEM/WB register indices and write enables,
//          MemRead_EX, PCSrc (taken branch), cnt_clr.
// Outputs: pc_ena, ifid_ena, ifid/idex/exmem flush strobes, fwd_a/fwd_b
//          (combinational); state, four saturating perf counters and the
//          sticky stall watchdog wdog_err (registered).
// -----------------------------------------------------------------------------
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_W        = 5,
    parameter int CNT_W        = 32,
    parameter int FWD_EN       = 1,
    parameter int BRANCH_STAGE = 1,
    parameter int MAX_STALL    = 7
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [REG_W-1:0] rs1_ID,
    input  logic [REG_W-1:0] rs2_ID,
    input  logic             use_rs1_ID,
    input  logic             use_rs2_ID,
    input  logic [REG_W-1:0] rs1_EX,
    input  logic [REG_W-1:0] rs2_EX,
    input  logic [REG_W-1:0] wrin_EX,
    input  logic [REG_W-1:0] wrin_MEM,
    input  logic [REG_W-1:0] wrin_WB,
    input  logic             RegWrite_EX,
    input  logic             RegWrite_MEM,
    input  logic             RegWrite_WB,
    input  logic             MemRead_EX,
    input  logic             PCSrc,
    input  logic             cnt_clr,
    output logic             pc_ena,
    output logic             ifid_ena,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] ret_cnt,
    output logic             wdog_err
);

    localparam int              RUN_W     = $clog2(MAX_STALL + 1);
    localparam logic [RUN_W-1:0] STALL_LIM = MAX_STALL[RUN_W-1:0];
    localparam logic [RUN_W-1:0] RUN_ONE   = {{(RUN_W-1){1'b0}}, 1'b1};

    // A producer only counts when it really writes a register other than x0.
    function automatic logic hit(input logic [REG_W-1:0] src,
                                 input logic [REG_W-1:0] dst,
                                 input logic             we);
        return we && (dst != {REG_W{1'b0}}) && (src == dst);
    endfunction

    logic       id_hit_ex_s, id_hit_mem_s, id_hit_wb_s;
    logic       stall_req_s;
    logic       stall_act_s;
    fwd_sel_t   fwd_a_s, fwd_b_s;

    state_t     state_q;
    logic [RUN_W-1:0] stall_run_q, stall_run_d;
    logic       wdog_q, wdog_d;

    // Source-vs-destination compares and the stall request.
    always_comb begin
        id_hit_ex_s  = (use_rs1_ID && hit(rs1_ID, wrin_EX,  RegWrite_EX))  ||
                       (use_rs2_ID && hit(rs2_ID, wrin_EX,  RegWrite_EX));
        id_hit_mem_s = (use_rs1_ID && hit(rs1_ID, wrin_MEM, RegWrite_MEM)) ||
                       (use_rs2_ID && hit(rs2_ID, wrin_MEM, RegWrite_MEM));
        id_hit_wb_s  = (use_rs1_ID && hit(rs1_ID, wrin_WB,  RegWrite_WB))  ||
                       (use_rs2_ID && hit(rs2_ID, wrin_WB,  RegWrite_WB));
        // The register bank has no write-through, so a WB collision stalls
        // even when forwarding covers the EX/MEM cases.
        if (FWD_EN != 0) begin
            stall_req_s = (MemRead_EX && id_hit_ex_s) || id_hit_wb_s;
        end else begin
            stall_req_s = id_hit_ex_s || id_hit_mem_s || id_hit_wb_s;
        end
        // A taken branch squashes the stalled instruction, so no stall then.
        stall_act_s = stall_req_s && !PCSrc && !RESET;
    end

    // Forwarding selects for the EX operands.
    always_comb begin
        if (FWD_EN != 0) begin
            fwd_a_s = fwd_select(hit(rs1_EX, wrin_MEM, RegWrite_MEM),
                                 hit(rs1_EX, wrin_WB,  RegWrite_WB));
            fwd_b_s = fwd_select(hit(rs2_EX, wrin_MEM, RegWrite_MEM),
                                 hit(rs2_EX, wrin_WB,  RegWrite_WB));
        end else begin
            fwd_a_s = FWD_REG;
            fwd_b_s = FWD_REG;
        end
    end

    // Pipeline enables, flush strobes and operand selects.
    always_comb begin
        pc_ena      = 1'b1;
        ifid_ena    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        fwd_a       = fwd_a_s;
        fwd_b       = fwd_b_s;
        if (RESET) begin
            pc_ena      = 1'b0;
            ifid_ena    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            fwd_a       = FWD_REG;
            fwd_b       = FWD_REG;
        end else if (PCSrc) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            // Resolved in MEM means the instruction in EX/MEM is wrong-path too.
            exmem_flush = (BRANCH_STAGE == 1);
        end else if (stall_req_s) begin
            pc_ena      = 1'b0;
            ifid_ena    = 1'b0;
            idex_flush  = 1'b1;
        end else begin
            pc_ena      = 1'b1;
            ifid_ena    = 1'b1;
        end
    end

    // Watchdog next state: consecutive-stall run length, saturating at the limit.
    always_comb begin
        stall_run_d = stall_run_q;
        if (stall_act_s) begin
            if (stall_run_q == STALL_LIM) begin
                stall_run_d = stall_run_q;
            end else begin
                stall_run_d = stall_run_q + RUN_ONE;
            end
        end else begin
            stall_run_d = {RUN_W{1'b0}};
        end
        wdog_d = wdog_q || (stall_run_d == STALL_LIM);
    end

    // Controller FSM plus watchdog registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= RUN;
            stall_run_q <= {RUN_W{1'b0}};
            wdog_q      <= 1'b0;
        end else begin
            if (PCSrc) begin
                state_q <= FLUSH;
            end else if (stall_req_s) begin
                state_q <= STALL;
            end else begin
                state_q <= RUN;
            end
            stall_run_q <= stall_run_d;
            wdog_q      <= wdog_d;
        end
    end

    assign state    = state_q;
    assign wdog_err = wdog_q;

    sat_counter #(.W(CNT_W)) u_cyc_cnt (
        .CLK(CLK), .RESET(RESET), .clr(cnt_clr), .inc(1'b1),        .q(cyc_cnt)
    );
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .CLK(CLK), .RESET(RESET), .clr(cnt_clr), .inc(stall_act_s), .q(stall_cnt)
    );
    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .CLK(CLK), .RESET(RESET), .clr(cnt_clr), .inc(PCSrc),       .q(flush_cnt)
    );
    sat_counter #(.W(CNT_W)) u_ret_cnt (
        .CLK(CLK), .RESET(RESET), .clr(cnt_clr), .inc(RegWrite_WB), .q(ret_cnt)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_unit
// Two instances share one stimulus: dut1 (forwarding, branch in MEM, 32-bit
// counters) and dut0 (pure interlock, branch in EX, 4-bit counters).
// -----------------------------------------------------------------------------
module tb_hazard_unit;

    logic       CLK, RESET;
    logic [4:0] rs1_ID, rs2_ID, rs1_EX, rs2_EX, wrin_EX, wrin_MEM, wrin_WB;
    logic       use_rs1_ID, use_rs2_ID, RegWrite_EX, RegWrite_MEM, RegWrite_WB;
    logic       MemRead_EX, PCSrc, cnt_clr;

    logic        pc_1, ifid_1, ifidf_1, idexf_1, exmemf_1, wdog_1;
    logic [1:0]  fa_1, fb_1, st_1;
    logic [31:0] cyc_1, stl_1, flc_1, ret_1;

    logic        pc_0, ifid_0, ifidf_0, idexf_0, exmemf_0, wdog_0;
    logic [1:0]  fa_0, fb_0, st_0;
    logic [3:0]  cyc_0, stl_0, flc_0, ret_0;

    int n_cmp = 0;
    int n_err = 0;

    hazard_unit #(.REG_W(5), .CNT_W(32), .FWD_EN(1), .BRANCH_STAGE(1), .MAX_STALL(7)) dut1 (
        .CLK(CLK), .RESET(RESET), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
        .use_rs1_ID(use_rs1_ID), .use_rs2_ID(use_rs2_ID), .rs1_EX(rs1_EX), .rs2_EX(rs2_EX),
        .wrin_EX(wrin_EX), .wrin_MEM(wrin_MEM), .wrin_WB(wrin_WB),
        .RegWrite_EX(RegWrite_EX), .RegWrite_MEM(RegWrite_MEM), .RegWrite_WB(RegWrite_WB),
        .MemRead_EX(MemRead_EX), .PCSrc(PCSrc), .cnt_clr(cnt_clr),
        .pc_ena(pc_1), .ifid_ena(ifid_1), .ifid_flush(ifidf_1), .idex_flush(idexf_1),
        .exmem_flush(exmemf_1), .fwd_a(fa_1), .fwd_b(fb_1), .state(st_1),
        .cyc_cnt(cyc_1), .stall_cnt(stl_1), .flush_cnt(flc_1), .ret_cnt(ret_1),
        .wdog_err(wdog_1)
    );

    hazard_unit #(.REG_W(5), .CNT_W(4), .FWD_EN(0), .BRANCH_STAGE(0), .MAX_STALL(7)) dut0 (
        .CLK(CLK), .RESET(RESET), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
        .use_rs1_ID(use_rs1_ID), .use_rs2_ID(use_rs2_ID), .rs1_EX(rs1_EX), .rs2_EX(rs2_EX),
        .wrin_EX(wrin_EX), .wrin_MEM(wrin_MEM), .wrin_WB(wrin_WB),
        .RegWrite_EX(RegWrite_EX), .RegWrite_MEM(RegWrite_MEM), .RegWrite_WB(RegWrite_WB),
        .MemRead_EX(MemRead_EX), .PCSrc(PCSrc), .cnt_clr(cnt_clr),
        .pc_ena(pc_0), .ifid_ena(ifid_0), .ifid_flush(ifidf_0), .idex_flush(idexf_0),
        .exmem_flush(exmemf_0), .fwd_a(fa_0), .fwd_b(fb_0), .state(st_0),
        .cyc_cnt(cyc_0), .stall_cnt(stl_0), .flush_cnt(flc_0), .ret_cnt(ret_0),
        .wdog_err(wdog_0)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [4:0] rs1_id, rs2_id;
        logic       use1, use2;
        logic [4:0] rs1_ex, rs2_ex, w_ex, w_mem, w_wb;
        logic       rw_ex, rw_mem, rw_wb, mem_rd, pcsrc;
        logic       st1, st0;          // stall action expected in dut1 / dut0
        logic [1:0] fa1, fb1;          // dut1 forwarding selects
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic [4:0] r1i, input logic [4:0] r2i, input logic u1, input logic u2,
        input logic [4:0] r1e, input logic [4:0] r2e,
        input logic [4:0] we, input logic rwe, input logic [4:0] wm, input logic rwm,
        input logic [4:0] ww, input logic rww, input logic mr, input logic pcs,
        input logic s1, input logic s0, input logic [1:0] a1, input logic [1:0] b1);
        vec_t v;
        v.rs1_id = r1i; v.rs2_id = r2i; v.use1 = u1; v.use2 = u2;
        v.rs1_ex = r1e; v.rs2_ex = r2e;
        v.w_ex = we; v.rw_ex = rwe; v.w_mem = wm; v.rw_mem = rwm; v.w_wb = ww; v.rw_wb = rww;
        v.mem_rd = mr; v.pcsrc = pcs; v.st1 = s1; v.st0 = s0; v.fa1 = a1; v.fb1 = b1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        rs1_ID = 5'd0; rs2_ID = 5'd0; use_rs1_ID = 1'b0; use_rs2_ID = 1'b0;
        rs1_EX = 5'd0; rs2_EX = 5'd0; wrin_EX = 5'd0; wrin_MEM = 5'd0; wrin_WB = 5'd0;
        RegWrite_EX = 1'b0; RegWrite_MEM = 1'b0; RegWrite_WB = 1'b0;
        MemRead_EX = 1'b0; PCSrc = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        idle_inputs();
    endtask

    // Combinational outputs of both instances for a known stall/branch outcome.
    task automatic chk_comb(input string nm, input logic pcs, input logic s1, input logic s0,
                            input logic [1:0] a1, input logic [1:0] b1);
        chk({nm, ".pc1"},    {31'd0, pc_1},     {31'd0, ~s1});
        chk({nm, ".ifid1"},  {31'd0, ifid_1},   {31'd0, ~s1});
        chk({nm, ".ifidf1"}, {31'd0, ifidf_1},  {31'd0, pcs});
        chk({nm, ".idexf1"}, {31'd0, idexf_1},  {31'd0, pcs | s1});
        chk({nm, ".exmf1"},  {31'd0, exmemf_1}, {31'd0, pcs});
        chk({nm, ".fa1"},    {30'd0, fa_1},     {30'd0, a1});
        chk({nm, ".fb1"},    {30'd0, fb_1},     {30'd0, b1});
        chk({nm, ".pc0"},    {31'd0, pc_0},     {31'd0, ~s0});
        chk({nm, ".idexf0"}, {31'd0, idexf_0},  {31'd0, pcs | s0});
        chk({nm, ".exmf0"},  {31'd0, exmemf_0}, 32'd0);
        chk({nm, ".fa0"},    {30'd0, fa_0},     32'd0);
        chk({nm, ".fb0"},    {30'd0, fb_0},     32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] s_ref, f_ref;
        int          nst;
        logic [4:0]  ex_w, mem_w, wb_w;

        // ---------------- reset behaviour ----------------
        idle_inputs();
        RESET = 1'b1;
        rs1_EX = 5'd7; wrin_MEM = 5'd7; RegWrite_MEM = 1'b1;   // would forward
        #1;
        chk("rst.pc",     {31'd0, pc_1},     32'd0);
        chk("rst.ifid",   {31'd0, ifid_1},   32'd0);
        chk("rst.flushes",{29'd0, ifidf_1, idexf_1, exmemf_1}, 32'd7);
        chk("rst.fa",     {30'd0, fa_1},     32'd0);
        step();
        chk("rst.state",  {30'd0, st_1},     32'd0);
        chk("rst.cyc",    cyc_1,             32'd0);
        chk("rst.stall",  stl_1,             32'd0);
        chk("rst.wdog",   {31'd0, wdog_1},   32'd0);
        RESET = 1'b0;
        idle_inputs();

        // ---------------- table-driven combinational vectors ----------------
        //             r1i  r2i  u1 u2 r1e  r2e  wex  rw  wmem rw  wwb  rw  mr pc  s1 s0 fa1    fb1
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00)); // idle
        vecs.push_back(mk(5, 1, 1, 1, 0, 0, 5, 1, 0, 0, 0, 0, 1, 0, 1, 1, 2'b00, 2'b00)); // load-use
        vecs.push_back(mk(5, 0, 1, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00)); // EX alu dep
        vecs.push_back(mk(0, 3, 0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00)); // MEM dep
        vecs.push_back(mk(9, 0, 1, 0, 0, 0, 0, 0, 0, 0, 9, 1, 0, 0, 1, 1, 2'b00, 2'b00)); // WB dep
        vecs.push_back(mk(9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 2'b00, 2'b00)); // source unused
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 1, 0, 1, 0, 1, 1, 0, 0, 0, 2'b00, 2'b00)); // x0 never stalls
        vecs.push_back(mk(0, 0, 0, 0, 7, 0, 0, 0, 7, 1, 7, 1, 0, 0, 0, 0, 2'b01, 2'b00)); // MEM over WB
        vecs.push_back(mk(0, 0, 0, 0, 7, 7, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 2'b10, 2'b10)); // WB fwd
        vecs.push_back(mk(0, 0, 0, 0, 0, 4, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01)); // MEM fwd b
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00)); // x0 no fwd
        vecs.push_back(mk(0, 0, 0, 0, 6, 6, 0, 0, 6, 0, 6, 0, 0, 0, 0, 0, 2'b00, 2'b00)); // no RegWrite
        vecs.push_back(mk(5, 1, 1, 1, 0, 0, 5, 1, 0, 0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00)); // branch over stall
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b00, 2'b00)); // branch alone
        vecs.push_back(mk(0, 3, 0, 1, 2, 3, 0, 0, 2, 1, 3, 1, 0, 0, 1, 1, 2'b01, 2'b10)); // mixed

        for (int i = 0; i < vecs.size(); i++) begin
            rs1_ID = vecs[i].rs1_id; rs2_ID = vecs[i].rs2_id;
            use_rs1_ID = vecs[i].use1; use_rs2_ID = vecs[i].use2;
            rs1_EX = vecs[i].rs1_ex; rs2_EX = vecs[i].rs2_ex;
            wrin_EX = vecs[i].w_ex; wrin_MEM = vecs[i].w_mem; wrin_WB = vecs[i].w_wb;
            RegWrite_EX = vecs[i].rw_ex; RegWrite_MEM = vecs[i].rw_mem; RegWrite_WB = vecs[i].rw_wb;
            MemRead_EX = vecs[i].mem_rd; PCSrc = vecs[i].pcsrc;
            #1;
            chk_comb($sformatf("v%0d", i), vecs[i].pcsrc, vecs[i].st1, vecs[i].st0,
                     vecs[i].fa1, vecs[i].fb1);
            step();
        end

        // ---------------- load-use, forwarding instance ----------------
        do_reset();
        wrin_EX = 5'd5; RegWrite_EX = 1'b1; MemRead_EX = 1'b1;           // lw x5 in EX
        rs1_ID = 5'd5; rs2_ID = 5'd1; use_rs1_ID = 1'b1; use_rs2_ID = 1'b1; // add x6,x5,x1
        #1;
        chk("lu.c1.pc",    {31'd0, pc_1},    32'd0);
        chk("lu.c1.idexf", {31'd0, idexf_1}, 32'd1);
        step();
        wrin_EX = 5'd0; RegWrite_EX = 1'b0; MemRead_EX = 1'b0;           // bubble in EX
        wrin_MEM = 5'd5; RegWrite_MEM = 1'b1;                            // lw in MEM
        #1;
        chk("lu.c2.pc",    {31'd0, pc_1},    32'd1);
        chk("lu.c2.state", {30'd0, st_1},    32'd1);
        step();
        idle_inputs();
        rs1_EX = 5'd5; rs2_EX = 5'd1;                                    // add in EX
        wrin_WB = 5'd5; RegWrite_WB = 1'b1;                              // lw in WB
        #1;
        chk("lu.c3.fa",    {30'd0, fa_1},    32'd2);
        chk("lu.c3.fb",    {30'd0, fb_1},    32'd0);
        chk("lu.c3.stall", stl_1,            32'd1);
        chk("lu.c3.state", {30'd0, st_1},    32'd0);
        step();

        // ---------------- branch over stall ----------------
        idle_inputs();
        wrin_EX = 5'd5; RegWrite_EX = 1'b1; MemRead_EX = 1'b1;
        rs1_ID = 5'd5; use_rs1_ID = 1'b1; PCSrc = 1'b1;
        #1;
        chk("bos.pc",      {31'd0, pc_1},    32'd1);
        chk("bos.flushes", {29'd0, ifidf_1, idexf_1, exmemf_1}, 32'd7);
        chk("bos.exmf0",   {31'd0, exmemf_0}, 32'd0);
        s_ref = stl_1; f_ref = flc_1;
        step();
        chk("bos.state",   {30'd0, st_1},    32'd2);
        chk("bos.flushcnt", flc_1,           f_ref + 32'd1);
        chk("bos.stallcnt", stl_1,           s_ref);

        // ---------------- interlock, no forwarding ----------------
        idle_inputs();
        step();
        ex_w = 5'd3; mem_w = 5'd0; wb_w = 5'd0;                          // addi x3 in EX
        rs1_ID = 5'd3; use_rs1_ID = 1'b1;                                // dependent in ID
        rs1_EX = 5'd3; rs2_EX = 5'd3;
        nst = 0;
        for (int c = 0; c < 8; c++) begin
            wrin_EX = ex_w;  RegWrite_EX  = (ex_w  != 5'd0);
            wrin_MEM = mem_w; RegWrite_MEM = (mem_w != 5'd0);
            wrin_WB = wb_w;  RegWrite_WB  = (wb_w  != 5'd0);
            #1;
            chk($sformatf("ilk.c%0d.fwd0", c), {28'd0, fa_0, fb_0}, 32'd0);
            if (pc_0) break;
            nst++;
            wb_w = mem_w; mem_w = ex_w; ex_w = 5'd0;
            step();
        end
        chk("ilk.stalls", nst, 32'd3);

        // ---------------- counters, saturation and clear ----------------
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        idle_inputs();
        repeat (20) step();
        chk("cnt.cyc0_sat", {28'd0, cyc_0}, 32'd15);
        chk("cnt.cyc1",     cyc_1,          32'd20);
        chk("cnt.ret1",     ret_1,          32'd0);
        cnt_clr = 1'b1; PCSrc = 1'b1;
        step();
        chk("cnt.clr.cyc1",   cyc_1,          32'd0);
        chk("cnt.clr.flush1", flc_1,          32'd0);
        chk("cnt.clr.cyc0",   {28'd0, cyc_0}, 32'd0);
        cnt_clr = 1'b0; PCSrc = 1'b0;
        step();
        chk("cnt.after.cyc1", cyc_1,          32'd1);
        chk("cnt.after.fl1",  flc_1,          32'd0);

        // ---------------- watchdog ----------------
        do_reset();
        wrin_WB = 5'd9; RegWrite_WB = 1'b1; rs1_ID = 5'd9; use_rs1_ID = 1'b1;
        repeat (6) step();
        chk("wd.6.wdog1", {31'd0, wdog_1}, 32'd0);
        chk("wd.6.wdog0", {31'd0, wdog_0}, 32'd0);
        step();
        chk("wd.7.wdog1", {31'd0, wdog_1}, 32'd1);
        chk("wd.7.wdog0", {31'd0, wdog_0}, 32'd1);
        chk("wd.7.stall", stl_1,           32'd7);
        chk("wd.7.ret",   ret_1,           32'd7);
        idle_inputs();
        step();
        step();
        chk("wd.rel.wdog", {31'd0, wdog_1}, 32'd1);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("wd.clr.wdog", {31'd0, wdog_1}, 32'd1);
        chk("wd.clr.cyc",  cyc_1,           32'd0);
        // reset arriving in the middle of a stall
        wrin_WB = 5'd9; RegWrite_WB = 1'b1; rs1_ID = 5'd9; use_rs1_ID = 1'b1;
        step();
        RESET = 1'b1;
        #1;
        chk("wd.rst.pc",      {31'd0, pc_1},    32'd0);
        chk("wd.rst.flushes", {29'd0, ifidf_1, idexf_1, exmemf_1}, 32'd7);
        step();
        chk("wd.rst.wdog",  {31'd0, wdog_1}, 32'd0);
        chk("wd.rst.state", {30'd0, st_1},   32'd0);
        chk("wd.rst.stall", stl_1,           32'd0);
        RESET = 1'b0;
        idle_inputs();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
